// File: rtl/s_stream_collector.sv
// Packs qualified s bits into WIDTH-bit frames with a valid/ready handoff,
// and runs an overlapping "101" detector with a saturating match counter.
module s_stream_collector #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             s_in_i,
  input  logic             s_valid_i,
  output logic [WIDTH-1:0] frame_data_o,
  output logic [CW-1:0]    ones_count_o,
  output logic             frame_valid_o,
  input  logic             frame_ready_i,
  output logic             match_o,
  output logic [7:0]       match_count_o,
  output logic             overflow_o
);

  typedef enum logic {FILL, HOLD} frame_st_e;
  typedef enum logic [1:0] {IDLE, GOT1, GOT10} det_st_e;

  frame_st_e        fst_q, fst_d;
  det_st_e          det_q, det_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    ones_q, ones_d;
  logic             fvalid_q, fvalid_d;
  logic             ovf_q, ovf_d;
  logic             match_q, match_d;
  logic [7:0]       mcnt_q, mcnt_d;
  logic [CW-1:0]    bit_ext;

  assign bit_ext = {{(CW-1){1'b0}}, s_in_i};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      fst_q    <= FILL;
      det_q    <= IDLE;
      shift_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      ones_q   <= '0;
      fvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      match_q  <= 1'b0;
      mcnt_q   <= '0;
    end else begin
      fst_q    <= fst_d;
      det_q    <= det_d;
      shift_q  <= shift_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      ones_q   <= ones_d;
      fvalid_q <= fvalid_d;
      ovf_q    <= ovf_d;
      match_q  <= match_d;
      mcnt_q   <= mcnt_d;
    end
  end

  // Frame assembly / handoff
  always_comb begin
    fst_d    = fst_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    ones_d   = ones_q;
    fvalid_d = fvalid_q;
    ovf_d    = ovf_q;
    case (fst_q)
      FILL: begin
        if (s_valid_i) begin
          if (cnt_q == CW'(WIDTH - 1)) begin
            data_d   = {shift_q[WIDTH-2:0], s_in_i};
            ones_d   = acc_q + bit_ext;
            shift_d  = '0;
            acc_d    = '0;
            cnt_d    = '0;
            fvalid_d = 1'b1;
            fst_d    = HOLD;
          end else begin
            shift_d = {shift_q[WIDTH-2:0], s_in_i};
            acc_d   = acc_q + bit_ext;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (frame_ready_i) begin
          fvalid_d = 1'b0;
          fst_d    = FILL;
          // A bit arriving with the handshake starts the next frame.
          if (s_valid_i) begin
            shift_d = {shift_q[WIDTH-2:0], s_in_i};
            acc_d   = bit_ext;
            cnt_d   = CW'(1);
          end
        end else if (s_valid_i) begin
          ovf_d = 1'b1;
        end
      end
      default: fst_d = FILL;
    endcase
  end

  // Detector sees every qualified bit, framed or dropped
  always_comb begin
    det_d   = det_q;
    match_d = 1'b0;
    mcnt_d  = mcnt_q;
    if (s_valid_i) begin
      case (det_q)
        IDLE:  det_d = s_in_i ? GOT1 : IDLE;
        GOT1:  det_d = s_in_i ? GOT1 : GOT10;
        GOT10: begin
          if (s_in_i) begin
            det_d   = GOT1;
            match_d = 1'b1;
          end else begin
            det_d = IDLE;
          end
        end
        default: det_d = IDLE;
      endcase
    end
    if (match_d && (mcnt_q != 8'hFF)) mcnt_d = mcnt_q + 8'd1;
  end

  assign frame_data_o  = data_q;
  assign ones_count_o  = ones_q;
  assign frame_valid_o = fvalid_q;
  assign match_o       = match_q;
  assign match_count_o = mcnt_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_s_stream_collector.sv
// Scenario bench for s_stream_collector against a bit-queue reference model.
module tb_s_stream_collector;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_in = 1'b0;
  logic          s_valid = 1'b0;
  logic          frame_ready = 1'b0;
  logic [W-1:0]  frame_data;
  logic [CW-1:0] ones_count;
  logic          frame_valid;
  logic          match;
  logic [7:0]    match_count;
  logic          overflow;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit            q[$];
  logic [W-1:0]  m_data;
  logic [CW-1:0] m_ones;
  logic          m_valid;
  logic          m_ovf;
  logic          m_match;
  logic [7:0]    m_mcnt;
  logic [2:0]    m_hist;

  s_stream_collector #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .s_in_i(s_in), .s_valid_i(s_valid),
    .frame_data_o(frame_data), .ones_count_o(ones_count),
    .frame_valid_o(frame_valid), .frame_ready_i(frame_ready),
    .match_o(match), .match_count_o(match_count), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input logic r, input logic sv, input logic si, input logic rdy);
    int ones;
    if (!r) begin
      q.delete();
      m_data = '0; m_ones = '0; m_valid = 1'b0; m_ovf = 1'b0;
      m_match = 1'b0; m_mcnt = '0; m_hist = '0;
      return;
    end
    m_match = 1'b0;
    if (sv) begin
      m_hist = {m_hist[1:0], si};
      if (m_hist == 3'b101) begin
        m_match = 1'b1;
        if (m_mcnt < 8'd255) m_mcnt = m_mcnt + 8'd1;
      end
    end
    if (m_valid) begin
      if (rdy) begin
        m_valid = 1'b0;
        if (sv) q.push_back(si);
      end else if (sv) begin
        m_ovf = 1'b1;
      end
    end else if (sv) begin
      q.push_back(si);
      if (q.size() == W) begin
        m_data = '0;
        ones = 0;
        foreach (q[i]) begin
          m_data = m_data * 2 + W'(q[i]);
          ones += int'(q[i]);
        end
        m_ones = CW'(ones);
        m_valid = 1'b1;
        q.delete();
      end
    end
  endtask

  // Drive one cycle, advance the model, land 1ns past the edge
  task automatic tick(input logic r, input logic sv, input logic si, input logic rdy);
    rst_n = r; s_valid = sv; s_in = si; frame_ready = rdy;
    @(posedge clk);
    model_edge(r, sv, si, rdy);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) tick(1'b0, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if ({frame_data, ones_count, frame_valid, match, match_count, overflow} !== '0) begin
      n_err++;
      $display("FAIL reset.outputs got data=%h ones=%0d fv=%b m=%b mc=%0d ovf=%b required all 0",
               frame_data, ones_count, frame_valid, match, match_count, overflow);
    end
  endtask

  task automatic test_basic_frame();
    logic [7:0] pat = 8'b1011_0010;
    int pulses = 0;
    for (int i = 7; i >= 0; i--) begin
      tick(1'b1, 1'b1, pat[i], 1'b1);
      pulses += int'(match);
      n_cmp++;
      if (frame_valid !== (i == 0)) begin
        n_err++;
        $display("FAIL basic.frame_valid bit %0d got %b required %b", 8 - i, frame_valid, i == 0);
      end
      n_cmp++;
      if (match !== m_match) begin
        n_err++;
        $display("FAIL basic.match bit %0d got %b required %b", 8 - i, match, m_match);
      end
    end
    n_cmp++;
    if (frame_data !== 8'hB2 || ones_count !== CW'(4)) begin
      n_err++;
      $display("FAIL basic.frame got %h/%0d required b2/4", frame_data, ones_count);
    end
    n_cmp++;
    if (pulses != 1 || match_count !== 8'd1) begin
      n_err++;
      $display("FAIL basic.matches got pulses=%0d count=%0d required 1/1", pulses, match_count);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (frame_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic.handshake frame_valid got %b required 0", frame_valid);
    end
  endtask

  task automatic test_gaps();
    logic [4:0] pat = 5'b10101;
    int pulses = 0;
    do_reset();
    for (int i = 4; i >= 0; i--) begin
      tick(1'b1, 1'b1, pat[i], 1'b1);
      pulses += int'(match);
      for (int g = 0; g < 2; g++) begin
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        pulses += int'(match);
      end
    end
    n_cmp++;
    if (pulses != 2 || match_count !== 8'd2) begin
      n_err++;
      $display("FAIL gaps.matches got pulses=%0d count=%0d required 2/2", pulses, match_count);
    end
    n_cmp++;
    if (frame_valid !== 1'b0) begin
      n_err++;
      $display("FAIL gaps.frame_valid got %b required 0", frame_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (frame_valid !== 1'b1 || frame_data !== 8'hFF || ones_count !== CW'(8)) begin
        n_err++;
        $display("FAIL bp.hold extra %0d got fv=%b data=%h ones=%0d required 1/ff/8",
                 i, frame_valid, frame_data, ones_count);
      end
    end
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL bp.overflow got %b required 1", overflow);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (frame_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp.handshake frame_valid got %b required 0", frame_valid);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b1, 1'($urandom_range(1)), 1'b0);
      n_cmp++;
      if (frame_valid !== (i == 7)) begin
        n_err++;
        $display("FAIL bp.refill bit %0d frame_valid got %b required %b", i + 1, frame_valid, i == 7);
      end
    end
    n_cmp++;
    if (frame_data !== m_data || ones_count !== m_ones || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL bp.next_frame got %h/%0d ovf=%b required %h/%0d ovf=1",
               frame_data, ones_count, overflow, m_data, m_ones);
    end
    // reset while holding drops the frame
    do_reset();
    n_cmp++;
    if (frame_valid !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL bp.reset_hold got fv=%b ovf=%b required 0/0", frame_valid, overflow);
    end
  endtask

  task automatic test_collision();
    do_reset();
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'($urandom_range(1)), 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (frame_valid !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL collide.handshake got fv=%b ovf=%b required 0/0", frame_valid, overflow);
    end
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (frame_valid !== 1'b1 || frame_data !== 8'h80 || ones_count !== CW'(1) || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL collide.frame got fv=%b data=%h ones=%0d ovf=%b required 1/80/1/0",
               frame_valid, frame_data, ones_count, overflow);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (frame_valid !== 1'b1 || frame_data !== 8'hFF || ones_count !== CW'(8)) begin
      n_err++;
      $display("FAIL resetmid.frame got fv=%b data=%h ones=%0d required 1/ff/8",
               frame_valid, frame_data, ones_count);
    end
  endtask

  task automatic test_saturation();
    int pulses = 0;
    int late = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      tick(1'b1, 1'b1, (i % 2 == 0), 1'b1);
      pulses += int'(match);
      if (i > 560) late += int'(match);
      n_cmp++;
      if (match !== m_match || match_count !== m_mcnt) begin
        n_err++;
        $display("FAIL sat.step %0d got m=%b mc=%0d required %b/%0d", i, match, match_count, m_match, m_mcnt);
      end
    end
    n_cmp++;
    if (match_count !== 8'd255 || pulses != 299 || late == 0) begin
      n_err++;
      $display("FAIL sat.final got count=%0d pulses=%0d late=%0d required 255/299/>0",
               match_count, pulses, late);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(199) != 0), ($urandom_range(3) != 0), 1'($urandom_range(1)),
           ($urandom_range(2) != 0));
      n_cmp++;
      if (frame_valid !== m_valid || frame_data !== m_data || ones_count !== m_ones) begin
        n_err++;
        $display("FAIL rand.frame cyc %0d got fv=%b data=%h ones=%0d required %b/%h/%0d",
                 i, frame_valid, frame_data, ones_count, m_valid, m_data, m_ones);
      end
      n_cmp++;
      if (match !== m_match || match_count !== m_mcnt || overflow !== m_ovf) begin
        n_err++;
        $display("FAIL rand.det cyc %0d got m=%b mc=%0d ovf=%b required %b/%0d/%b",
                 i, match, match_count, overflow, m_match, m_mcnt, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_gaps();
    test_backpressure();
    test_collision();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/s_stream_collector.md
# s_stream_collector

Sequential stage directly downstream of the team's single-output combinational logic function. It samples the one-bit `s` result each clock when qualified by `s_valid` and packs the bits into WIDTH-bit frames. Each frame is handed off through a valid/ready handshake together with its count of ones. The block also runs an overlapping "101" sequence detector on the same bit stream and keeps a saturating match count.

## Interface
- `WIDTH`, default 8: bits per frame; legal range 2..32.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `s_in`  input  1  bit from the combinational stage.
- `s_valid`  input  1  `s_in` is meaningful this cycle.
- `frame_data`  output  WIDTH  assembled frame; the first accepted bit is the MSB.
- `ones_count`  output  $clog2(WIDTH+1)  number of 1s in `frame_data`.
- `frame_valid`  output  1  frame available.
- `frame_ready`  input  1  consumer accepts the frame.
- `match`  output  1  one-cycle pulse per detected "101".
- `match_count`  output  8  saturating count of matches.
- `overflow`  output  1  sticky flag: a bit was dropped while a frame was held.

## Operation
- Frame FSM has two states:
  - FILL: each cycle with `s_valid`=1, the block does shift = {shift[WIDTH-2:0], s_in}, adds `s_in` to the ones accumulator, and increments `bit_cnt`.
  - When `bit_cnt` reaches WIDTH, the block loads `frame_data`/`ones_count`, clears `bit_cnt`/accumulator, sets `frame_valid`=1 and moves to HOLD.
  - Cycles with `s_valid`=0 change no frame state.
- HOLD:
  - `frame_data`, `ones_count` and `frame_valid` stay stable until `frame_valid`&`frame_ready`.
  - On handshake: `frame_valid`→0, state→FILL.
  - If `s_valid`=1 in the same cycle as the handshake, that bit is accepted as bit 1 of the next frame, and `overflow` is unchanged.
  - If `s_valid`=1 in HOLD without a handshake, the bit is dropped from framing and `overflow`←1.
  - `overflow` clears only on reset.
- Detector FSM states: IDLE, GOT1, GOT10. It advances on every `s_valid`=1 bit, including bits dropped from framing.
  - IDLE: 1→GOT1; 0→IDLE.
  - GOT1: 0→GOT10; 1→GOT1.
  - GOT10: 1→GOT1 with match; 0→IDLE.
  - Overlap is allowed, so "10101" gives 2 matches.
- `match_count` increments on each match and holds at 255.
- Arithmetic: `ones_count` ≤ WIDTH, no wrap. `bit_cnt` counts 0..WIDTH-1 and never exceeds it.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - All outputs go to 0: `frame_data`, `ones_count`, `frame_valid`, `match`, `match_count`, `overflow`.
  - FSMs go to FILL/IDLE; `bit_cnt` and shift register clear.
  - Reset overrides all inputs.
  - Reset mid-frame or mid-HOLD discards the partial or held frame with no handshake.
- `frame_valid` rises on the clock edge that samples the WIDTH-th accepted bit (visible the following cycle). Minimum frame-to-frame spacing is WIDTH accepted bits.
- `match` is registered: it is high for exactly the one cycle following the edge that sampled the completing "1".
  - Back-to-back matches produce separate single-cycle pulses.
  - `match_count` updates on the same edge that raises `match`.
- `frame_ready` while `frame_valid`=0 has no effect.
- No combinational path from any input to any output.

## Test plan
1. Reset: `rst_n`=0 for 2 cycles with `s_valid`=1, `s_in`=1 → every output 0; after release, FSMs start from FILL/IDLE.
2. Basic frame (WIDTH=8): feed 1,0,1,1,0,0,1,0 on consecutive cycles with `frame_ready`=1:
   - `frame_valid` for one cycle after the 8th bit, with `frame_data`=8'hB2 and `ones_count`=4.
   - One `match` pulse after bit 3; `match_count`=1.
3. Gaps and overlap: feed 1,0,1,0,1 with `s_valid`=0 cycles inserted between bits → 2 `match` pulses, `match_count`=2, no frame.
4. Backpressure: `frame_ready`=0; complete frame 8'hFF, then 3 more valid bits:
   - `frame_data` held at 8'hFF, `ones_count`=8, `overflow`=1.
   - Then `frame_ready`=1 → handshake; the next frame needs 8 fresh bits.
5. Handshake collision: in HOLD, assert `frame_ready`=1 and `s_valid`=1 with `s_in`=1 in the same cycle, then feed 7 zeros → next frame 8'h80, `overflow`=0.
6. Reset mid-frame and saturation:
   - 5 bits, then reset, then 8 ones → frame 8'hFF (not merged with the earlier bits).
   - Separately, feed "10" repeated 300 times → `match_count` stops at 255 while `match` keeps pulsing.
